// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider controller and its counter datapath.
package clk_div_pkg;

  localparam int unsigned DivWidth   = 16;
  localparam int unsigned DefaultDiv = 1;

  typedef enum logic [1:0] {
    StStop,
    StRun,
    StPend
  } state_e;

endpackage

// File: rtl/div_counter.sv
// Half-period counter and output toggle; strobes flag the cycle before oclk rises or falls.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned W = DivWidth
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         run_i,
  input  logic [W-1:0] div_i,
  output logic         clk_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         wrap;

  assign wrap = run_i && (cnt_q == div_i - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (run_i) begin
      if (wrap) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = wrap & ~clk_q;
  assign fall_o = wrap & clk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop FSM plus divisor-load handshake around div_counter.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned W           = DivWidth,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         ien,
  input  logic [W-1:0] idiv,
  input  logic         ivalid,
  output logic         oready,
  output logic         oclk,
  output logic         otick,
  output logic         obusy,
  output logic         oerr
);

  state_e       state_q;
  logic [W-1:0] div_q;
  logic [W-1:0] pend_q;
  logic         otick_q, oerr_q, obusy_q, oready_q;
  logic         rise, fall;
  logic         xfer, load;

  assign xfer = ivalid & oready_q;
  assign load = xfer & (idiv != '0);

  div_counter #(
    .W(W)
  ) u_counter (
    .clk_i  (iclk),
    .clear_i(irst),
    .run_i  (state_q != StStop),
    .div_i  (div_q),
    .clk_o  (oclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= StStop;
      div_q    <= W'(DEFAULT_DIV);
      pend_q   <= '0;
      otick_q  <= 1'b0;
      oerr_q   <= 1'b0;
      obusy_q  <= 1'b0;
      oready_q <= 1'b1;
    end else begin
      otick_q <= rise;
      oerr_q  <= xfer & (idiv == '0);
      unique case (state_q)
        StStop: begin
          if (load) div_q <= idiv;
          if (ien) begin
            state_q <= StRun;
            obusy_q <= 1'b1;
          end
        end
        StRun: begin
          // Stopping on this boundary: a coincident load behaves like a load in STOP.
          if (fall && !ien) begin
            state_q <= StStop;
            obusy_q <= 1'b0;
            if (load) div_q <= idiv;
          end else if (load) begin
            pend_q   <= idiv;
            state_q  <= StPend;
            oready_q <= 1'b0;
          end
        end
        StPend: begin
          if (fall) begin
            div_q    <= pend_q;
            oready_q <= 1'b1;
            if (ien) begin
              state_q <= StRun;
            end else begin
              state_q <= StStop;
              obusy_q <= 1'b0;
            end
          end
        end
        default: state_q <= StStop;
      endcase
    end
  end

  assign otick  = otick_q;
  assign oerr   = oerr_q;
  assign obusy  = obusy_q;
  assign oready = oready_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench: stimulus queues expected output-change events {oclk,otick,obusy,oready,oerr}
// with the cycle gap since the previous change; the monitor compares each change as it appears.
module tb_clk_div_ctrl;

  logic        iclk;
  logic        irst;
  logic        ien;
  logic [15:0] idiv;
  logic        ivalid;
  logic        oready, oclk, otick, obusy, oerr;

  clk_div_ctrl #(
    .W          (16),
    .DEFAULT_DIV(1)
  ) dut (
    .iclk  (iclk),
    .irst  (irst),
    .ien   (ien),
    .idiv  (idiv),
    .ivalid(ivalid),
    .oready(oready),
    .oclk  (oclk),
    .otick (otick),
    .obusy (obusy),
    .oerr  (oerr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic [4:0]  exp_vec_q[$];
  int unsigned exp_dt_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // dt of 0 leaves the gap unchecked (used only for the very first event).
  task automatic ev(input logic [4:0] v, input int unsigned d);
    exp_vec_q.push_back(v);
    exp_dt_q.push_back(d);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, reports every change of the output vector.
  initial begin
    logic [4:0]  prev, cur, ev_v;
    int unsigned cyc, last, ev_d;
    prev = 5'b00010;
    cyc  = 0;
    last = 0;
    @(posedge iclk);
    forever begin
      @(negedge iclk);
      cyc++;
      cur = {oclk, otick, obusy, oready, oerr};
      if (cur !== prev) begin
        n_vec++;
        if (exp_vec_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %b after %0d cycles, required no change",
                   cur, cyc - last);
        end else begin
          ev_v = exp_vec_q.pop_front();
          ev_d = exp_dt_q.pop_front();
          if (cur !== ev_v || (ev_d != 0 && (cyc - last) != ev_d)) begin
            n_err++;
            $display("FAIL event_%0d: got %b after %0d cycles, required %b after %0d cycles",
                     n_vec, cur, cyc - last, ev_v, ev_d);
          end
        end
        prev = cur;
        last = cyc;
      end
    end
  end

  initial begin
    irst   = 1'b1;
    ien    = 1'b0;
    ivalid = 1'b0;
    idiv   = '0;
    tick(3);

    // D=1 after reset: period 2, otick every rise.
    ev(5'b00110, 0); ev(5'b11110, 1); ev(5'b00110, 1); ev(5'b11110, 1);
    ev(5'b00110, 1); ev(5'b11110, 1); ev(5'b00010, 1);
    irst = 1'b0; ien = 1'b1;
    tick(6);
    irst = 1'b1; ien = 1'b0;
    tick(2);

    // Load D=3 in STOP, run, reload D=5 in high phase, then stop during a high phase.
    ev(5'b00110, 3); ev(5'b11110, 3); ev(5'b10110, 1); ev(5'b00110, 2);
    ev(5'b11110, 3); ev(5'b10110, 1); ev(5'b10100, 1); ev(5'b00110, 1);
    ev(5'b11110, 5); ev(5'b10110, 1); ev(5'b00110, 4); ev(5'b11110, 5);
    ev(5'b10110, 1); ev(5'b00010, 4);
    irst = 1'b0; ivalid = 1'b1; idiv = 16'd3;
    tick(1);
    ivalid = 1'b0; ien = 1'b1;
    tick(11);
    ivalid = 1'b1; idiv = 16'd5;
    tick(1);
    ivalid = 1'b0;
    tick(17);
    ien = 1'b0;
    tick(6);

    // Zero loads in STOP and RUN; then D=4 via PEND and stop requested during a low phase.
    ev(5'b00011, 3); ev(5'b00010, 1); ev(5'b00110, 1); ev(5'b11110, 5);
    ev(5'b10110, 1); ev(5'b10111, 2); ev(5'b10110, 1); ev(5'b00110, 1);
    ev(5'b11110, 5); ev(5'b10110, 1); ev(5'b00110, 4); ev(5'b00100, 2);
    ev(5'b11100, 3); ev(5'b10100, 1); ev(5'b00110, 4); ev(5'b11110, 4);
    ev(5'b10110, 1); ev(5'b00110, 3); ev(5'b11110, 4); ev(5'b10110, 1);
    ev(5'b00010, 3);
    ivalid = 1'b1; idiv = 16'd0;
    tick(1);
    ivalid = 1'b0;
    tick(1);
    ien = 1'b1;
    tick(8);
    ivalid = 1'b1; idiv = 16'd0;
    tick(1);
    ivalid = 1'b0;
    tick(13);
    ivalid = 1'b1; idiv = 16'd4;
    tick(1);
    ivalid = 1'b0;
    tick(17);
    ien = 1'b0;
    tick(8);

    // Reset while PEND holds D=7: pending value lost, restart runs at D=1.
    ev(5'b00110, 2); ev(5'b11110, 4); ev(5'b10110, 1); ev(5'b10100, 1);
    ev(5'b00010, 1); ev(5'b00110, 2); ev(5'b11110, 1); ev(5'b00110, 1);
    ev(5'b11110, 1); ev(5'b00010, 1);
    ien = 1'b1;
    tick(6);
    ivalid = 1'b1; idiv = 16'd7;
    tick(1);
    ivalid = 1'b0; irst = 1'b1; ien = 1'b0;
    tick(2);
    irst = 1'b0; ien = 1'b1;
    tick(4);
    irst = 1'b1; ien = 1'b0;
    tick(3);

    while (exp_vec_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_event: got no change, required %b after %0d cycles",
               exp_vec_q.pop_front(), exp_dt_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
